// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master single-beat bus arbiter, IDLE -> ISSUE -> RESP per transaction.
// Define ARB_RR_EN for round-robin tie-break; otherwise master 0 has fixed priority.
module bus_arbiter #(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst,
    input  logic          m0_req,
    input  logic [AW-1:0] m0_addr,
    input  logic          m0_wen,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic [AW-1:0] m1_addr,
    input  logic          m1_wen,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic [AW-1:0] Bus_addr,
    output logic [DW-1:0] Bus_wdata,
    output logic          Bus_wen,
    input  logic [DW-1:0] Bus_rdata
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t        state_q, state_d;
    logic          owner_q, owner_d;
    logic          wen_q, wen_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic          arb, win;
`ifdef ARB_RR_EN
    logic          last_q, last_d;
`endif
    always_comb begin
        arb      = (state_q != ISSUE) && (m0_req || m1_req);
`ifdef ARB_RR_EN
        win      = (m0_req && m1_req) ? ~last_q : m1_req;
        last_d   = arb ? win : last_q;
`else
        win      = ~m0_req;
`endif
        state_d  = arb ? ISSUE : (state_q == ISSUE ? RESP : IDLE);
        owner_d  = arb ? win : owner_q;
        addr_d   = arb ? (win ? m1_addr : m0_addr) : addr_q;
        wdata_d  = arb ? (win ? m1_wdata : m0_wdata) : wdata_q;
        wen_d    = arb && (win ? m1_wen : m0_wen);
        // read data is captured at the end of ISSUE, even for writes
        rdata0_d = (state_q == ISSUE && !owner_q) ? Bus_rdata : rdata0_q;
        rdata1_d = (state_q == ISSUE && owner_q) ? Bus_rdata : rdata1_q;
    end
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            wen_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wen_q    <= wen_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end
`ifdef ARB_RR_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst)
            last_q <= 1'b1;
        else
            last_q <= last_d;
    end
`endif
    assign m0_gnt    = (state_q == ISSUE) && !owner_q;
    assign m1_gnt    = (state_q == ISSUE) && owner_q;
    assign m0_rvalid = (state_q == RESP) && !owner_q;
    assign m1_rvalid = (state_q == RESP) && owner_q;
    assign m0_rdata  = rdata0_q;
    assign m1_rdata  = rdata1_q;
    assign Bus_addr  = addr_q;
    assign Bus_wdata = wdata_q;
    assign Bus_wen   = wen_q;
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master arbiter that shares the single peripheral data bus (the Bridge side: `Bus_addr`, `Bus_wdata`, `Bus_wen`, `Bus_rdata`) between the CPU load/store path (master 0) and a second requester such as a debug/DMA port (master 1).
- Each master issues single-beat read or write transactions with a req/gnt handshake.
- The arbiter registers the winning request onto the bus, then samples the read data.
- It returns that data to the winner with a one-cycle valid pulse.
- It sits between the core's bus interface and the Bridge.

## Interface

Parameters:
- `DW`, 32, data width of the bus and of both master data ports.
- `AW`, 32, address width.

Ports:
- `cpu_clk`, in, 1: the single clock.
- `cpu_rst`, in, 1: reset, synchronous, active-high.
- `m0_req`, in, 1: master 0 transaction request. Held with its addr/wen/wdata until `m0_gnt`.
- `m0_addr`, in, AW: master 0 address.
- `m0_wen`, in, 1: master 0 write (1) or read (0).
- `m0_wdata`, in, DW: master 0 write data.
- `m0_gnt`, out, 1: one-cycle pulse, high in the ISSUE cycle of master 0's transaction.
- `m0_rvalid`, out, 1: one-cycle pulse, high in the RESP cycle of master 0's transaction.
- `m0_rdata`, out, DW: read data; valid while `m0_rvalid` is high.
- `m1_req`, `m1_addr`, `m1_wen`, `m1_wdata`, `m1_gnt`, `m1_rvalid`, `m1_rdata`: the same set of ports for master 1.
- `Bus_addr`, out, AW: registered bus address.
- `Bus_wdata`, out, DW: registered bus write data.
- `Bus_wen`, out, 1: registered write strobe, high only in ISSUE of a write.
- `Bus_rdata`, in, DW: bus read data, combinational from the Bridge for the current `Bus_addr`.

## Operation

- FSM states: IDLE, ISSUE, RESP. Reset state is IDLE.
- Arbitration happens in IDLE and RESP.
  - If no req is high, the FSM goes to or stays in IDLE.
  - Otherwise it picks the winner, latches that master's addr, wen and wdata into the bus registers, records the `owner`, and goes to ISSUE.
- ISSUE:
  - `Bus_*` carry the latched request.
  - `mX_gnt` is 1 for the owner.
  - `Bus_wen` is 1 only if the latched wen is 1.
  - At the end of the cycle, `Bus_rdata` is captured into the owner's `rdata` register. This capture also happens for writes, where the captured value is don't-care.
  - The FSM always goes to RESP.
- RESP:
  - `mX_rvalid` is 1 for the owner.
  - `Bus_wen` is 0.
  - Arbitration runs again, so back-to-back transactions are possible.
  - A master's req that is still high in RESP counts as a new transaction. Masters drop req the cycle after gnt unless they have another transaction.
- Tie-break when both reqs are high: set by `ARB_RR_EN` (see Configuration).
- `Bus_addr` and `Bus_wdata` hold their last value outside ISSUE. `Bus_wen` is 0 outside ISSUE.
- `mX_rdata` holds its value until that master's next capture.
- A request that drops before being granted is simply not served. The arbiter never generates a transaction from stale inputs.
- Reset mid-transaction: the FSM returns to IDLE and all outputs return to their reset values on the next edge. The in-flight transaction is abandoned with no rvalid.

## Timing

- Reset values (all outputs): `mX_gnt` = 0, `mX_rvalid` = 0, `mX_rdata` = 0, `Bus_addr` = 0, `Bus_wdata` = 0, `Bus_wen` = 0. Internal `owner` = 0, `last` = 1.
- Latency: req sampled high at edge N, gnt in cycle N+1, rvalid and rdata in cycle N+2.
- Peak throughput: one transaction every 2 cycles (ISSUE, RESP, ISSUE, ...).
- The write side effect happens at the end of the ISSUE cycle.
- `gnt` and `rvalid` are never high for both masters in the same cycle.
- `gnt` is never high in two consecutive cycles.

## Configuration

- `ARB_RR_EN` defined: round-robin arbitration.
  - On a tie, the master that is not `last` wins.
  - `last` updates to the winner on every grant.
  - Reset `last` = 1, so master 0 wins the first tie.
- `ARB_RR_EN` undefined: fixed priority. Master 0 always wins ties, and the `last` register is not implemented.

## Test plan

- Single read:
  - Stimulus: `m0_req`=1, `m0_addr`=0x1000, `m0_wen`=0 at edge 0, with the Bridge model returning 0xDEADBEEF for 0x1000.
  - Response: `m0_gnt`=1 and `Bus_addr`=0x1000 in cycle 1; `m0_rvalid`=1 and `m0_rdata`=0xDEADBEEF in cycle 2; `m1_*` outputs stay 0 throughout.
- Single write:
  - Stimulus: `m1_req`=1, `m1_addr`=0x2004, `m1_wdata`=0x12345678, `m1_wen`=1.
  - Response: `Bus_wen`=1 for exactly one cycle (cycle 1), with `Bus_wdata`=0x12345678; memory at 0x2004 reads back 0x12345678; `m1_rvalid` pulses in cycle 2.
- Contention (with `ARB_RR_EN`):
  - Stimulus: both reqs held high continuously from reset release.
  - Response: grant order 0,1,0,1; gnt pulses spaced 2 cycles apart.
- Contention (without `ARB_RR_EN`):
  - Stimulus: both reqs held high continuously.
  - Response: master 0 wins every grant and `m1_gnt` never asserts.
- Withdrawn request:
  - Stimulus: `m1_req` high for 1 cycle while master 0 is in ISSUE, then low by RESP.
  - Response: no `m1_gnt`; FSM returns to IDLE.
- Reset in ISSUE:
  - Stimulus: assert `cpu_rst` during the gnt cycle of a read.
  - Response: next cycle all outputs are 0 and no rvalid occurs; a new req after reset release is served normally with 2-cycle latency.
